morse_link_sequencer: RTL and testbench
=======================================

Name: morse_link_sequencer

Overview:
- Single-clock controller that sequences one Morse loopback/transmit session.
- Transmit side: fetches characters from the input ROM, hands each to the coder, loads the 24-bit code word into the IOD serializer, then spaces characters with an inter-character gap.
- Receive side: in parallel, collects decoded characters and writes them sequentially into the output ROM.
- Replaces free-running address counters with a start/done/error handshake.

Parameters:
- ADR_W, 16, width of input/output ROM addresses.
- MAX_CHARS, 4096, maximum characters per session (address limit, both sides).
- ENC_LAT, 1, coder latency in clk cycles from enc_x valid to enc_y valid.
- GAP_TICKS, 3, inter-character gap in dot ticks.
- TIMEOUT_TICKS, 64, dot ticks allowed in WAIT_TX before error.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse; begins a session from address 0.
- abort, in, 1, one-cycle pulse; returns to IDLE.
- tick, in, 1, one-cycle dot-period strobe from the NCO.
- rom_cs, out, 1, input ROM chip select.
- rom_adr, out, ADR_W, input ROM address.
- rom_data, in, 8, input ROM data, valid 1 cycle after rom_cs.
- enc_x, out, 8, character to coder.
- enc_y, in, 24, code word from coder.
- tx_load, out, 1, one-cycle load strobe to serializer.
- tx_word, out, 24, word loaded into serializer.
- tx_busy, in, 1, serializer shifting.
- rx_valid, in, 1, one-cycle strobe: decoded character available.
- rx_char, in, 8, decoded character.
- out_we, out, 1, output ROM write enable.
- out_adr, out, ADR_W, output ROM write address.
- out_data, out, 8, output ROM write data.
- busy, out, 1, session active.
- done, out, 1, session finished normally; sticky until start or reset.
- err, out, 1, timeout; sticky until start or reset.
- rx_ovf, out, 1, receive write dropped at limit; sticky until start or reset.

Behaviour:
- Reset (rst=0 at posedge): all outputs 0, state IDLE, all counters 0.
- States and transitions:
  - IDLE: on start → FETCH; rom_adr cleared; out_adr cleared; done, err and rx_ovf cleared.
  - FETCH: rom_cs=1 for exactly one cycle → CHECK.
  - CHECK: rom_data sampled.
    - 0x00 (terminator) → DONE.
    - Otherwise: enc_x latched; → ENCODE.
  - ENCODE: waits ENC_LAT cycles; enc_y latched into tx_word → LOAD.
  - LOAD:
    - If tx_busy=0: tx_load=1 for one cycle → WAIT_TX.
    - Otherwise remain in LOAD.
  - WAIT_TX:
    - Waits for tx_busy to rise, then fall → GAP.
    - Ticks are counted from LOAD exit; if the count reaches TIMEOUT_TICKS first → ERROR.
  - GAP:
    - Counts GAP_TICKS ticks, then increments rom_adr.
    - If the new rom_adr == MAX_CHARS → DONE; otherwise → FETCH.
  - DONE: done=1, busy=0; start → new session.
  - ERROR: err=1, busy=0; start → new session.
- busy=1 in every state except IDLE, DONE and ERROR.
- Character latency: start to first tx_load = 2 + ENC_LAT + 1 cycles when tx_busy=0 (4 cycles at default).
- Receive path (independent of FSM):
  - rx_valid=1 with busy=1 or DONE: out_we=1, out_data=rx_char on the next cycle, out_adr=current write pointer; the pointer increments after the write.
  - Write pointer saturates at MAX_CHARS; further rx_valid drops the write and sets rx_ovf.
  - rx_valid in IDLE or ERROR is ignored.
- Simultaneous events:
  - abort has priority over start and over all transitions; → IDLE next cycle, tx_load forced 0, flags unchanged.
  - start while busy=1 is ignored.
  - tick coinciding with a state entry counts toward that state's counter.
  - rx_valid during a start cycle is ignored (pointer is being cleared).
- Reset mid-session: immediate return to the reset state on the next edge, regardless of tx_busy.
- Arithmetic:
  - rom_adr and out_adr are unsigned, ADR_W wide.
  - Comparisons against MAX_CHARS use ADR_W+1 bits, so no wrap occurs.
  - Tick counters are clog2(TIMEOUT_TICKS+1) wide.

Decomposition:
- Shared package morse_pkg:
  - state enum (IDLE, FETCH, CHECK, ENCODE, LOAD, WAIT_TX, GAP, DONE, ERROR);
  - CODE_W=24;
  - CHAR_TERM=8'h00.
- One sub-module: morse_rx_writer, containing the receive path (write pointer, saturation, rx_ovf).
- FSM and tick counters stay in the top level.

Test Plan:
- ROM "SOS" then 0x00; tx_busy model holds 20 ticks per load → exactly 3 tx_load pulses, rom_adr 0→3, done=1, busy=0, err=0.
- tx_busy stuck 0 after load, TIMEOUT_TICKS=64 → err=1 on the 64th tick, busy=0, no further tx_load; start then restarts at rom_adr=0 with err cleared.
- rx_valid pulses with 'S','O','S' → out_we pulses at out_adr 0,1,2, data 0x53,0x4F,0x53, each 1 cycle after its strobe.
- MAX_CHARS=4 with a ROM lacking a terminator → 4 loads, done after rom_adr reaches 4; 5 rx_valid strobes → 4 writes, rx_ovf=1.
- abort during GAP, plus start and abort in the same cycle → state IDLE, no tx_load; start in the same cycle ignored.
- rst=0 during WAIT_TX → all outputs 0 at the next edge; start pulse issued while busy=1 ignored; tx_load gap spacing equals 3 ticks.

Source files
------------

// File: rtl/morse_pkg.sv
// Constants shared by the Morse link sequencer and its receive writer.
package morse_pkg;
    localparam int unsigned CODE_W = 24;
    localparam int unsigned ST_W   = 4;
    localparam logic [7:0]  CHAR_TERM = 8'h00;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_FETCH   = 4'd1;
    localparam logic [3:0] ST_CHECK   = 4'd2;
    localparam logic [3:0] ST_ENCODE  = 4'd3;
    localparam logic [3:0] ST_LOAD    = 4'd4;
    localparam logic [3:0] ST_WAIT_TX = 4'd5;
    localparam logic [3:0] ST_GAP     = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    // A session is active everywhere except the three resting states.
    function automatic logic state_busy(input logic [ST_W-1:0] st);
        return !((st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR));
    endfunction
endpackage

// File: rtl/morse_rx_writer.sv
// Receive path: writes decoded characters to the output ROM through a saturating pointer.
module morse_rx_writer
    import morse_pkg::*;
#(
    parameter int unsigned ADR_W     = 16,
    parameter int unsigned MAX_CHARS = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             rx_valid,
    input  logic [7:0]       rx_char,
    output logic             out_we,
    output logic [ADR_W-1:0] out_adr,
    output logic [7:0]       out_data,
    output logic             rx_ovf
);
    localparam logic [ADR_W:0] MAX_L = (ADR_W+1)'(MAX_CHARS);

    // One bit wider than the address so a limit of 2**ADR_W cannot wrap.
    logic [ADR_W:0] ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            out_we   <= 1'b0;
            out_adr  <= '0;
            out_data <= '0;
            rx_ovf   <= 1'b0;
        end else begin
            out_we <= 1'b0;
            if (clr) begin
                ptr    <= '0;
                rx_ovf <= 1'b0;
            end else if (en && rx_valid) begin
                if (ptr == MAX_L) begin
                    rx_ovf <= 1'b1;
                end else begin
                    out_we   <= 1'b1;
                    out_adr  <= ptr[ADR_W-1:0];
                    out_data <= rx_char;
                    ptr      <= ptr + (ADR_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: rtl/morse_link_sequencer.sv
// Sequences one Morse session: ROM fetch, encode, serializer load, inter-character gap,
// with a parallel receive writer and start/done/error handshake.
module morse_link_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned ADR_W         = 16,
    parameter int unsigned MAX_CHARS     = 4096,
    parameter int unsigned ENC_LAT       = 1,
    parameter int unsigned GAP_TICKS     = 3,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tick,
    output logic              rom_cs,
    output logic [ADR_W-1:0]  rom_adr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        enc_x,
    input  logic [CODE_W-1:0] enc_y,
    output logic              tx_load,
    output logic [CODE_W-1:0] tx_word,
    input  logic              tx_busy,
    input  logic              rx_valid,
    input  logic [7:0]        rx_char,
    output logic              out_we,
    output logic [ADR_W-1:0]  out_adr,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rx_ovf
);
    localparam int unsigned TICK_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned ENC_W  = $clog2(ENC_LAT + 1);
    localparam int unsigned CNT_W  = (TICK_W > ENC_W) ? TICK_W : ENC_W;
    localparam logic [ADR_W:0]   MAX_L = (ADR_W+1)'(MAX_CHARS);
    localparam logic [CNT_W-1:0] TO_L  = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] GAP_L = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] ENC_L = CNT_W'(ENC_LAT);

    logic [ST_W-1:0]   state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              seen, seen_next;
    logic [ADR_W-1:0]  rom_adr_next;
    logic [ADR_W:0]    adr_inc;
    logic [7:0]        enc_x_next;
    logic [CODE_W-1:0] tx_word_next;
    logic              tx_load_next, rom_cs_next, busy_next, done_next, err_next;
    logic              start_acc;
    logic              rx_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            seen    <= 1'b0;
            rom_cs  <= 1'b0;
            rom_adr <= '0;
            enc_x   <= '0;
            tx_load <= 1'b0;
            tx_word <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            seen    <= seen_next;
            rom_cs  <= rom_cs_next;
            rom_adr <= rom_adr_next;
            enc_x   <= enc_x_next;
            tx_load <= tx_load_next;
            tx_word <= tx_word_next;
            busy    <= busy_next;
            done    <= done_next;
            err     <= err_next;
        end
    end

    // Next-state and next-output logic; abort overrides everything but leaves flags alone.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        seen_next    = seen;
        rom_adr_next = rom_adr;
        enc_x_next   = enc_x;
        tx_word_next = tx_word;
        tx_load_next = 1'b0;
        done_next    = done;
        err_next     = err;
        start_acc    = 1'b0;
        cnt_inc      = cnt + CNT_W'(1);
        adr_inc      = {1'b0, rom_adr} + (ADR_W+1)'(1);

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        start_acc    = 1'b1;
                        state_next   = ST_FETCH;
                        rom_adr_next = '0;
                        done_next    = 1'b0;
                        err_next     = 1'b0;
                    end
                end
                ST_FETCH: state_next = ST_CHECK;
                ST_CHECK: begin
                    if (rom_data == CHAR_TERM) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        enc_x_next = rom_data;
                        cnt_next   = '0;
                        state_next = ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == ENC_L) begin
                        tx_word_next = enc_y;
                        state_next   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy) begin
                        tx_load_next = 1'b1;
                        cnt_next     = '0;
                        seen_next    = 1'b0;
                        state_next   = ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (tx_busy) seen_next = 1'b1;
                    if (tick) cnt_next = cnt_inc;
                    // A completed shift wins over a timeout landing in the same cycle.
                    if (seen && !tx_busy) begin
                        cnt_next   = '0;
                        state_next = ST_GAP;
                    end else if (tick && (cnt_inc == TO_L)) begin
                        err_next   = 1'b1;
                        state_next = ST_ERROR;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == GAP_L) begin
                            rom_adr_next = adr_inc[ADR_W-1:0];
                            if (adr_inc == MAX_L) begin
                                done_next  = 1'b1;
                                state_next = ST_DONE;
                            end else begin
                                state_next = ST_FETCH;
                            end
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        rom_cs_next = (state_next == ST_FETCH);
        busy_next   = state_busy(state_next);
    end

    assign rx_en = state_busy(state) || (state == ST_DONE);

    morse_rx_writer #(
        .ADR_W     (ADR_W),
        .MAX_CHARS (MAX_CHARS)
    ) u_rx_writer (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .en       (rx_en),
        .rx_valid (rx_valid),
        .rx_char  (rx_char),
        .out_we   (out_we),
        .out_adr  (out_adr),
        .out_data (out_data),
        .rx_ovf   (rx_ovf)
    );
endmodule

// File: tb/tb_morse_link_sequencer.sv
// Directed bench for morse_link_sequencer with ROM, coder and serializer models and scoreboards.
module tb_morse_link_sequencer;
    localparam int unsigned SER_TICKS = 20;
    localparam int unsigned GAP_T     = 3;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, tick;
    logic        rom_cs, tx_load, tx_busy, rx_valid, out_we, busy, done, err, rx_ovf;
    logic [15:0] rom_adr, out_adr;
    logic [7:0]  rom_data, enc_x, rx_char, out_data;
    logic [23:0] enc_y, tx_word;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_load = 0, n_we = 0;
    int ser_cnt = 0, gap_cnt = 0, to_cnt = 0, tick_div = 0;
    logic gap_meas = 1'b0, to_meas = 1'b0, ser_stuck = 1'b0, model_clr = 1'b0;
    logic [7:0]  rom [8];
    logic [7:0]  sos [3] = '{8'h53, 8'h4F, 8'h53};
    logic [23:0] tx_q [$];
    wr_t         rx_q [$];
    wr_t         w;
    logic [23:0] exp_w;

    morse_link_sequencer #(.MAX_CHARS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
        .rom_cs(rom_cs), .rom_adr(rom_adr), .rom_data(rom_data),
        .enc_x(enc_x), .enc_y(enc_y), .tx_load(tx_load), .tx_word(tx_word), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_char(rx_char), .out_we(out_we), .out_adr(out_adr),
        .out_data(out_data), .busy(busy), .done(done), .err(err), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [23:0] code_of(input logic [7:0] c);
        return {c, ~c, c ^ 8'h5A};
    endfunction

    always_comb enc_y = code_of(enc_x);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b1; model_clr = 1'b1;
        step(1);
        start = 1'b0; model_clr = 1'b0;
    endtask

    // Models run on the falling edge; `tick` here is still the value the DUT just sampled.
    always @(negedge clk) begin
        if (model_clr) begin
            tx_busy = 1'b0; ser_cnt = 0; gap_meas = 1'b0; gap_cnt = 0; to_meas = 1'b0; to_cnt = 0;
        end else begin
            if (tick) begin
                if (to_meas) to_cnt++;
                if (gap_meas) gap_cnt++;
                if (tx_busy) begin
                    ser_cnt++;
                    if (ser_cnt == SER_TICKS) begin
                        tx_busy = 1'b0; gap_meas = 1'b1; gap_cnt = 0;
                    end
                end
            end
            if (tx_load) begin
                n_load++;
                exp_w = (tx_q.size() != 0) ? tx_q.pop_front() : 'x;
                chk("tx_word", tx_word, exp_w);
                if (gap_meas) begin
                    chk("gap_ticks", gap_cnt, GAP_T);
                    gap_meas = 1'b0;
                end
                to_meas = 1'b1; to_cnt = 0;
                if (!ser_stuck) begin
                    tx_busy = 1'b1; ser_cnt = 0;
                end
            end
        end
        if (out_we) begin
            n_we++;
            if (rx_q.size() != 0) w = rx_q.pop_front();
            else begin w.adr = 'x; w.data = 'x; w.cyc = -1; end
            chk("wr_adr", out_adr, w.adr);
            chk("wr_data", out_data, w.data);
            chk("wr_cycle", cyc, w.cyc);
        end
        tick_div = (tick_div == 4) ? 0 : tick_div + 1;
        tick = (tick_div == 0);
        if (rom_cs) rom_data = rom[rom_adr[2:0]];
    end

    initial begin
        int l0, w0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_char = '0;
        tx_busy = 1'b0; tick = 1'b0; rom_data = '0;
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        step(3);
        chk("reset_outs", {rom_cs, rom_adr, enc_x, tx_load, tx_word, out_we, out_adr, out_data,
                           busy, done, err, rx_ovf}, '0);
        rst = 1'b1;
        step(2);

        // "SOS" session with receive strobes while transmitting
        rom[0] = 8'h53; rom[1] = 8'h4F; rom[2] = 8'h53; rom[3] = 8'h00;
        for (int i = 0; i < 3; i++) tx_q.push_back(code_of(sos[i]));
        l0 = n_load;
        start_session();
        chk("start_busy", busy, 1'b1);
        chk("fetch_rom_cs", rom_cs, 1'b1);
        step(3);
        chk("latency_early", tx_load, 1'b0);
        step(1);
        chk("latency_load", tx_load, 1'b1);
        chk("latency_word", tx_word, code_of(8'h53));
        step(2);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_char = sos[i];
            rx_q.push_back('{adr: 16'(i), data: sos[i], cyc: cyc + 1});
            step(1);
            rx_valid = 1'b0;
            step(1);
        end
        for (int i = 0; i < 2000 && !done; i++) step(1);
        chk("sos_done", done, 1'b1);
        chk("sos_loads", n_load - l0, 3);
        chk("sos_rom_adr", rom_adr, 16'd3);
        chk("sos_busy", busy, 1'b0);
        chk("sos_err", err, 1'b0);
        chk("sos_writes", n_we, 3);

        // Address limit: no terminator, rx strobe during start ignored, 5 strobes -> 4 writes
        for (int i = 0; i < 8; i++) rom[i] = 8'h41 + 8'(i);
        for (int i = 0; i < 4; i++) tx_q.push_back(code_of(8'h41 + 8'(i)));
        l0 = n_load; w0 = n_we;
        rx_valid = 1'b1; rx_char = 8'h77;
        start_session();
        rx_valid = 1'b0;
        chk("lim_start_done_clr", done, 1'b0);
        step(2);
        chk("start_cycle_rx_ignored", n_we - w0, 0);
        for (int i = 0; i < 3000 && !done; i++) step(1);
        chk("lim_done", done, 1'b1);
        chk("lim_loads", n_load - l0, 4);
        chk("lim_rom_adr", rom_adr, 16'd4);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_char = 8'h61 + 8'(i);
            if (i < 4) rx_q.push_back('{adr: 16'(i), data: 8'h61 + 8'(i), cyc: cyc + 1});
            step(1);
            rx_valid = 1'b0;
            step(1);
            if (i == 3) chk("ovf_before", rx_ovf, 1'b0);
        end
        step(1);
        chk("ovf_after", rx_ovf, 1'b1);
        chk("lim_writes", n_we - w0, 4);

        // Serializer never goes busy -> timeout on the 64th tick
        rom[0] = 8'h54; rom[1] = 8'h00;
        tx_q.push_back(code_of(8'h54));
        ser_stuck = 1'b1;
        l0 = n_load;
        start_session();
        chk("to_ovf_cleared", rx_ovf, 1'b0);
        for (int i = 0; i < 1000 && to_cnt < 63; i++) step(1);
        chk("to_tick63_err", err, 1'b0);
        chk("to_tick63_busy", busy, 1'b1);
        for (int i = 0; i < 20 && to_cnt < 64; i++) step(1);
        chk("to_tick64_err", err, 1'b1);
        chk("to_tick64_busy", busy, 1'b0);
        step(30);
        chk("to_no_more_loads", n_load - l0, 1);
        w0 = n_we;
        rx_valid = 1'b1; rx_char = 8'h21;
        step(1);
        rx_valid = 1'b0;
        step(2);
        chk("err_rx_ignored", n_we - w0, 0);

        // Restart from ERROR
        ser_stuck = 1'b0;
        tx_q.push_back(code_of(8'h54));
        start_session();
        chk("restart_err_clr", err, 1'b0);
        chk("restart_rom_adr", rom_adr, 16'd0);
        chk("restart_busy", busy, 1'b1);
        for (int i = 0; i < 2000 && !done; i++) step(1);
        chk("restart_done", done, 1'b1);

        // start and abort together from DONE: start ignored, flags kept
        l0 = n_load;
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1'b0);
        chk("sa_done_kept", done, 1'b1);
        chk("sa_rom_cs", rom_cs, 1'b0);
        step(10);
        chk("sa_no_load", n_load - l0, 0);

        // abort in the middle of the inter-character gap
        rom[0] = 8'h53; rom[1] = 8'h4F; rom[2] = 8'h53; rom[3] = 8'h00;
        tx_q.push_back(code_of(8'h53));
        l0 = n_load;
        start_session();
        for (int i = 0; i < 500 && !gap_meas; i++) step(1);
        chk("ab_gap_reached", gap_meas, 1'b1);
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_flags", {done, err}, 2'b00);
        chk("ab_rom_adr", rom_adr, 16'd0);
        step(40);
        chk("ab_no_load", n_load - l0, 1);

        // reset during WAIT_TX, with a start pulse while busy
        tx_q.push_back(code_of(8'h53));
        l0 = n_load;
        start_session();
        for (int i = 0; i < 50 && n_load == l0; i++) step(1);
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_start_rom_cs", rom_cs, 1'b0);
        chk("busy_start_busy", busy, 1'b1);
        chk("wait_tx_busy_high", tx_busy, 1'b1);
        rst = 1'b0;
        step(1);
        chk("midrst_outs", {rom_cs, rom_adr, enc_x, tx_load, tx_word, out_we, out_adr, out_data,
                            busy, done, err, rx_ovf}, '0);
        rst = 1'b1; model_clr = 1'b1;
        step(1);
        model_clr = 1'b0;
        step(30);
        chk("midrst_no_load", n_load - l0, 1);
        chk("midrst_idle", busy, 1'b0);

        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
